decode_issue: RTL

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue_pkg.sv | 52 +++++
 rtl/decode_issue_inst_fifo.sv | 71 +++++++
 rtl/decode_issue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/decode_issue_pkg.sv
// Shared decode constants and helpers for the issue stage.
// Contents:
//   - bit positions of every field in the 32-bit instruction word
//   - issue-stage state encoding (RUN / HALT)
//   - dec_t       : decoded instruction fields
//   - decode_inst : pure combinational field extraction + immediate formation
// Datapath and ALU code import this package so that field positions live in one place.
package decode_issue_pkg;

  localparam int INST_W    = 32;
  localparam int OP_LSB    = 0;
  localparam int OP_W      = 7;
  localparam int YSEL_BIT  = 7;
  localparam int WRITE_BIT = 8;
  localparam int RD_LSB    = 9;
  localparam int RA_LSB    = 14;
  localparam int RB_LSB    = 19;
  localparam int REG_W     = 5;
  localparam int IMM_LSB   = 19;
  localparam int IMM_W     = 13;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              y_sel;
    logic              write;
    logic [REG_W-1:0]  addr_d;
    logic [REG_W-1:0]  addr_a;
    logic [REG_W-1:0]  addr_b;
    logic [INST_W-1:0] immed;
  } dec_t;

  // The immediate overlaps addr_b; it is only meaningful when the B operand
  // is not a register, so it reads as zero for register-B instructions.
  function automatic dec_t decode_inst(input logic [INST_W-1:0] inst);
    dec_t d;
    d.op     = inst[OP_LSB +: OP_W];
    d.y_sel  = inst[YSEL_BIT];
    d.write  = inst[WRITE_BIT];
    d.addr_d = inst[RD_LSB +: REG_W];
    d.addr_a = inst[RA_LSB +: REG_W];
    d.addr_b = inst[RB_LSB +: REG_W];
    d.immed  = d.y_sel ? '0
                       : {{(INST_W-IMM_W){inst[INST_W-1]}}, inst[IMM_LSB +: IMM_W]};
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_inst_fifo.sv
// Instruction FIFO for the decode/issue stage.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   push_i       : write wdata_i (ignored when full or flushing)
//   pop_i        : advance the head (ignored when empty or flushing)
//   flush_i      : empty the FIFO; overrides same-cycle push/pop
//   wdata_i      : instruction word to store
//   rdata_o      : current head word (valid when count_o != 0)
//   count_o      : number of buffered entries
// Head is read combinationally so a word pushed at one edge can be issued
// on the very next edge.
module decode_issue_inst_fifo
  import decode_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INST_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Full check uses the registered count, so a full FIFO refuses a push even
  // when the head is leaving in the same cycle.
  assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i  && !flush_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/decode_issue.sv
// Decode and issue stage: buffers instruction words, decodes the head and
// issues one legal ALU instruction per cycle; handles HALT and illegal ops.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid/in_inst   : instruction offer; accepted when in_ready
//   in_ready           : FIFO has room (from registered count)
//   stall              : downstream hold, no issue this cycle
//   flush              : drop all buffered words (and a same-cycle offer)
//   resume             : leave HALT
//   op..write          : registered fields of the last issued instruction
//   out_valid          : one-cycle pulse per issued instruction
//   halted             : in HALT state
//   illegal            : sticky, set when an unknown op is dropped
//   fifo_count         : buffered entries
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter logic [6:0] OP_MAX  = 7'd15,
  parameter logic [6:0] HALT_OP = 7'h7F
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [31:0]              in_inst,
  output logic                     in_ready,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     resume,
  output logic [6:0]               op,
  output logic [4:0]               addr_a,
  output logic [4:0]               addr_b,
  output logic [4:0]               addr_d,
  output logic [31:0]              immed,
  output logic                     y_sel,
  output logic                     write,
  output logic                     out_valid,
  output logic                     halted,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e      state_q, state_d;
  dec_t        fields_q, fields_d;
  logic        out_valid_q, out_valid_d;
  logic        illegal_q, illegal_d;
  logic [31:0] head_word;
  dec_t        head_dec;
  logic        push, pop;

  assign in_ready = (fifo_count < CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (state_q == ST_RUN) && !stall && !flush && (fifo_count != '0);

  decode_issue_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) inst_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (in_inst),
    .rdata_o (head_word),
    .count_o (fifo_count)
  );

  assign head_dec = decode_inst(head_word);

  // Pops only happen in RUN, so a HALT_OP pop and a resume can never
  // collide on the same edge. HALT_OP is checked first so it wins even if
  // OP_MAX is ever configured to cover it.
  always_comb begin
    state_d     = state_q;
    fields_d    = fields_q;
    out_valid_d = 1'b0;
    illegal_d   = illegal_q;
    if (state_q == ST_HALT && resume) state_d = ST_RUN;
    if (pop) begin
      if (head_dec.op == HALT_OP) begin
        state_d = ST_HALT;
      end else if (head_dec.op <= OP_MAX) begin
        fields_d    = head_dec;
        out_valid_d = 1'b1;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      fields_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fields_q    <= fields_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign op        = fields_q.op;
  assign addr_a    = fields_q.addr_a;
  assign addr_b    = fields_q.addr_b;
  assign addr_d    = fields_q.addr_d;
  assign immed     = fields_q.immed;
  assign y_sel     = fields_q.y_sel;
  // Write strobe only accompanies an issued instruction.
  assign write     = out_valid_q & fields_q.write;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == ST_HALT);
  assign illegal   = illegal_q;

endmodule
